// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared types and sizing helpers for the frequency gate controller
package freq_pkg;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_COUNT = 3'd2,
    S_LATCH = 3'd3,
    S_SHOW  = 3'd4
  } ctrlState_e;

  // Scalar control flags decoded from a state (enable is handled separately)
  typedef struct packed {
    logic clear;
    logic latch;
    logic done;
    logic busy;
  } ctrlFlags_s;

  // Gate counter must hold the longest gate, GATE_BASE << (2**MODE_W - 1)
  function automatic int gateCntWidth(input int gateBase, input int modeW);
    longint maxLen;
    maxLen = longint'(gateBase) << ((1 << modeW) - 1);
    return $clog2(maxLen) + 1;
  endfunction

  // Dwell counter must hold HOLD_CYCLES
  function automatic int dwellCntWidth(input int holdCycles);
    return $clog2(holdCycles) + 1;
  endfunction

  // Moore flag decode shared by the output register
  function automatic ctrlFlags_s stateFlags(input ctrlState_e s);
    ctrlFlags_s f;
    f = '0;
    case (s)
      S_IDLE:  f.clear = 1'b1;
      S_CLEAR: begin
        f.clear = 1'b1;
        f.busy  = 1'b1;
      end
      S_COUNT: f.busy = 1'b1;
      S_LATCH: begin
        f.latch = 1'b1;
        f.done  = 1'b1;
        f.busy  = 1'b1;
      end
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_gate_timer.sv
// rtl/freq_gate_ctrl_gate_timer.sv - loadable down-counter with terminal-count flag
module gate_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clkControl,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             decrement,
  output logic             terminal
);

  logic [CNT_W-1:0] count;

  // Load wins over decrement; decrement saturates at zero so a held dwell stays expired
  always_ff @(posedge clkControl) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (decrement && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Terminal while on the final counted cycle (1) or already expired (0)
  assign terminal = (count <= CNT_W'(1));

endmodule

// File: rtl/freq_gate_ctrl.sv
// rtl/freq_gate_ctrl.sv - gate-time sequencer driving counter clear/enable/latch
module freq_gate_ctrl
  import freq_pkg::*;
#(
  parameter int MODE_W      = 2,
  parameter int NUM_CH      = 4,
  parameter int GATE_BASE   = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic              clkControl,
  input  logic              rst,
  input  logic [MODE_W-1:0] testMode,
  input  logic              modeControl,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              hold,
  output logic [NUM_CH-1:0] enable,
  output logic              clear,
  output logic              latch,
  output logic              done,
  output logic              busy
);

  localparam int GATE_W  = gateCntWidth(GATE_BASE, MODE_W);
  localparam int DWELL_W = dwellCntWidth(HOLD_CYCLES);

  ctrlState_e        state;
  ctrlState_e        stateNext;
  logic [NUM_CH-1:0] shadowMask;
  logic [MODE_W-1:0] shadowMode;
  logic              shadowCtl;
  logic [NUM_CH-1:0] maskNext;
  logic [GATE_W-1:0] gateLen;
  logic              modeChange;
  logic              gateDone;
  logic              dwellDone;
  ctrlFlags_s        flagsNext;

  // Gate length follows the live testMode; it is only loaded while in CLEAR
  assign gateLen = GATE_W'(GATE_BASE) << testMode;

  // Any departure from the settings captured in CLEAR restarts the measurement
  assign modeChange = (testMode != shadowMode) || (modeControl != shadowCtl);

  // Mask that COUNT will use: the fresh capture on the CLEAR->COUNT edge, else the shadow
  assign maskNext = (state == S_CLEAR) ? ch_mask : shadowMask;

  gate_timer #(
    .CNT_W(GATE_W)
  ) u_gateTimer (
    .clkControl(clkControl),
    .rst       (rst),
    .load      (state == S_CLEAR),
    .loadValue (gateLen),
    .decrement (state == S_COUNT),
    .terminal  (gateDone)
  );

  gate_timer #(
    .CNT_W(DWELL_W)
  ) u_dwellTimer (
    .clkControl(clkControl),
    .rst       (rst),
    .load      (state == S_LATCH),
    .loadValue (DWELL_W'(HOLD_CYCLES)),
    .decrement (state == S_SHOW),
    .terminal  (dwellDone)
  );

  // State register
  always_ff @(posedge clkControl) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic; a mode change outranks gate or dwell expiry
  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE: begin
        if (!hold) stateNext = S_CLEAR;
      end
      S_CLEAR: begin
        stateNext = S_COUNT;
      end
      S_COUNT: begin
        if (modeChange)    stateNext = S_CLEAR;
        else if (gateDone) stateNext = S_LATCH;
      end
      S_LATCH: begin
        if (modeChange) stateNext = S_CLEAR;
        else            stateNext = S_SHOW;
      end
      S_SHOW: begin
        if (modeChange)              stateNext = S_CLEAR;
        else if (dwellDone && !hold) stateNext = S_CLEAR;
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

  // Capture the measurement settings for the whole gate while in CLEAR
  always_ff @(posedge clkControl) begin
    if (rst) begin
      shadowMask <= '0;
      shadowMode <= '0;
      shadowCtl  <= 1'b0;
    end else if (state == S_CLEAR) begin
      shadowMask <= ch_mask;
      shadowMode <= testMode;
      shadowCtl  <= modeControl;
    end
  end

  assign flagsNext = stateFlags(stateNext);

  // Registered Moore outputs, decoded from the state being entered so they align with it
  always_ff @(posedge clkControl) begin
    if (rst) begin
      enable <= '0;
      clear  <= 1'b1;
      latch  <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      enable <= (stateNext == S_COUNT) ? maskNext : '0;
      clear  <= flagsNext.clear;
      latch  <= flagsNext.latch;
      done   <= flagsNext.done;
      busy   <= flagsNext.busy;
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb/tb_freq_gate_ctrl.sv - directed scoreboard bench for freq_gate_ctrl
module tb_freq_gate_ctrl;

  localparam int MODE_W      = 2;
  localparam int NUM_CH      = 4;
  localparam int GATE_BASE   = 4;
  localparam int HOLD_CYCLES = 3;

  typedef struct {
    logic [7:0] v;
    string      tag;
  } expT;

  logic              clkControl = 1'b0;
  logic              rst = 1'b1;
  logic [MODE_W-1:0] testMode = '0;
  logic              modeControl = 1'b0;
  logic [NUM_CH-1:0] ch_mask = 4'b1011;
  logic              hold = 1'b0;
  logic [NUM_CH-1:0] enable;
  logic              clear;
  logic              latch;
  logic              done;
  logic              busy;

  expT expQ[$];
  int  compared = 0;
  int  mismatched = 0;

  always #5 clkControl = ~clkControl;

  freq_gate_ctrl #(
    .MODE_W     (MODE_W),
    .NUM_CH     (NUM_CH),
    .GATE_BASE  (GATE_BASE),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clkControl (clkControl),
    .rst        (rst),
    .testMode   (testMode),
    .modeControl(modeControl),
    .ch_mask    (ch_mask),
    .hold       (hold),
    .enable     (enable),
    .clear      (clear),
    .latch      (latch),
    .done       (done),
    .busy       (busy)
  );

  // Expected output vector layout: {enable[3:0], clear, latch, done, busy}
  task automatic pushN(input logic [3:0] en, input logic [3:0] flags, input string tag, input int n);
    expT e;
    for (int i = 0; i < n; i++) begin
      e.v   = {en, flags};
      e.tag = tag;
      expQ.push_back(e);
    end
  endtask

  task automatic pushIdle(input int n, input string tag);
    pushN(4'b0000, 4'b1000, tag, n);
  endtask

  task automatic pushClear(input string tag);
    pushN(4'b0000, 4'b1001, tag, 1);
  endtask

  task automatic pushCount(input logic [3:0] mask, input int n, input string tag);
    pushN(mask, 4'b0001, tag, n);
  endtask

  task automatic pushLatch(input string tag);
    pushN(4'b0000, 4'b0111, tag, 1);
  endtask

  task automatic pushShow(input int n, input string tag);
    pushN(4'b0000, 4'b0000, tag, n);
  endtask

  task automatic pushMeas(input logic [3:0] mask, input int n, input string tag);
    pushClear({tag, "_clear"});
    pushCount(mask, n, {tag, "_count"});
    pushLatch({tag, "_latch"});
    pushShow(HOLD_CYCLES, {tag, "_show"});
  endtask

  // Wait until every queued expectation has been checked; returns just after a falling edge
  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < budget) begin
      @(negedge clkControl);
      #1;
      n++;
    end
    compared++;
    assert (expQ.size() == 0) else begin
      mismatched++;
      $error("FAIL %s_timeout: observed %0d pending, required 0", tag, expQ.size());
      expQ.delete();
    end
  endtask

  // Scoreboard checker: one expectation per cycle, sampled on the falling edge
  always @(negedge clkControl) begin : monitor
    expT        e;
    logic [7:0] obs;
    if (expQ.size() > 0) begin
      e   = expQ.pop_front();
      obs = {enable, clear, latch, done, busy};
      compared++;
      assert (obs === e.v) else begin
        mismatched++;
        $error("FAIL %s: observed en=%b clr/lat/dn/bsy=%b required en=%b clr/lat/dn/bsy=%b",
               e.tag, obs[7:4], obs[3:0], e.v[7:4], e.v[3:0]);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clkControl);
    @(negedge clkControl);
    #1;
    pushIdle(2, "reset");
    drain("reset", 10);

    // Released with hold high: stays in IDLE
    rst  = 1'b0;
    hold = 1'b1;
    pushIdle(3, "hold_idle");
    drain("hold_idle", 10);

    // Mode 0, mask 1011: two back-to-back 9-cycle periods
    hold = 1'b0;
    pushMeas(4'b1011, 4, "m0a");
    pushMeas(4'b1011, 4, "m0b");
    drain("m0", 40);

    // Mode 3: 32-cycle gate; mask change mid-gate must not affect it
    testMode = 2'd3;
    pushMeas(4'b1011, 32, "m3");
    repeat (5) begin
      @(negedge clkControl);
      #1;
    end
    ch_mask = 4'b0101;
    drain("m3", 60);

    // Mode 0 with new mask; testMode 0->1 in second COUNT cycle aborts
    testMode = 2'd0;
    pushClear("ab_clear");
    pushCount(4'b0101, 2, "ab_count");
    drain("ab_pre", 10);
    testMode = 2'd1;
    pushMeas(4'b0101, 8, "m1");
    drain("m1", 30);

    // modeControl toggle on last COUNT cycle: abort wins, no latch
    testMode = 2'd0;
    pushClear("last_clear");
    pushCount(4'b0101, 4, "last_count");
    drain("last_pre", 10);
    modeControl = 1'b1;
    pushClear("mc_clear");
    pushCount(4'b0101, 4, "mc_count");
    pushLatch("mc_latch");
    pushShow(1, "mc_show");
    drain("mc", 20);

    // Mode change during SHOW restarts
    modeControl = 1'b0;
    pushClear("show_ab_clear");
    pushCount(4'b0101, 2, "hold_count_a");
    drain("show_ab", 10);

    // hold rises mid-COUNT: measurement completes, SHOW persists
    hold = 1'b1;
    pushCount(4'b0101, 2, "hold_count_b");
    pushLatch("hold_latch");
    pushShow(20, "hold_show");
    drain("hold", 40);
    hold = 1'b0;
    pushClear("unhold_clear");
    pushCount(4'b0101, 3, "rst_count");
    drain("unhold", 10);

    // Reset during third COUNT cycle
    rst = 1'b1;
    pushIdle(2, "rst_mid");
    drain("rst_mid", 10);
    rst = 1'b0;
    pushMeas(4'b0101, 4, "post_rst");
    drain("post_rst", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
